div_unit: RTL and testbench
===========================

# div_unit

Multi-cycle 32-bit integer divider for the EX stage, serving MIPS DIV/DIVU. Performs a radix-2 restoring division, one quotient bit per cycle, and returns {remainder, quotient} as a 64-bit word. The EX stage stalls the pipeline while a division is in flight. Through EX/MEM/WB, the upper half becomes HI and the lower half becomes LO, and both are written into the HI/LO register pair.

## Interface
- No parameters; datapath fixed at 32-bit operands, 64-bit result.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- start_i  in  1  request/hold a division; must stay high until result is consumed
- annul_i  in  1  cancel in-flight division (branch flush / exception)
- signed_div_i  in  1  1 = DIV (signed), 0 = DIVU
- opdata1_i  in  32  dividend
- opdata2_i  in  32  divisor
- result_o  out  64  {remainder[31:0], quotient[31:0]}
- ready_o  out  1  result_o valid

## Operation
- States: FREE, BYZERO, ON, END; 6-bit iteration counter cnt.
- FREE: on start_i=1 and annul_i=0, latch signed_div_i, the sign of each operand and the operand magnitudes. Magnitude = two's-complement negation when signed_div_i=1 and the operand MSB=1, otherwise the raw value.
  - divisor==0: go to BYZERO.
  - otherwise: go to ON; cnt=0; partial remainder R(33b)=0; Q=|dividend|.
  - Inputs after the latch edge are ignored except start_i and annul_i.
- ON, cnt<32: one iteration. {R,Q} is shifted left by 1. Trial T=R−{0,|divisor|}. If T≥0, R=T and Q[0]=1; else R is kept and Q[0]=0. cnt++.
- ON, cnt==32: sign fix-up, then go to END.
  - Quotient is negated if signed and the latched operand signs differ.
  - Remainder is negated if signed and the latched dividend was negative.
  - Results wrap mod 2^32. Example: 0x80000000/0xFFFFFFFF signed gives q=0x80000000, r=0.
- BYZERO: final quotient and remainder are 0; go to END.
- END: drive result_o={rem,quot} and ready_o=1. Hold while start_i=1. When start_i=0, go to FREE and clear result_o and ready_o to 0.
- Abort: in ON or BYZERO, if annul_i=1 or start_i=0, go to FREE with ready_o=0 and result_o=0. No result is produced.
- annul_i=1 in FREE blocks a start on that edge.
- annul_i in END is ignored; only start_i=0 releases END.
- Reset: state=FREE, cnt=0, R=0, Q=0, result_o=64'h0, ready_o=0. Reset has priority over every other event, including mid-division.

## Timing
- Start sampled at edge N (FREE→ON): iterations occur at edges N+1..N+32, fix-up at edge N+33 (→END), and ready_o/result_o are valid after edge N+34.
- Divide-by-zero: start at edge N (→BYZERO), edge N+1 (→END), ready_o=1 after edge N+2 with result 0.
- ready_o stays high exactly as long as start_i stays high after completion. It drops one edge after start_i falls.
- A new start is accepted in FREE only, at the earliest the edge after returning from END. There are no back-to-back starts from END.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- DIVU 100/7, start held: ready_o=0 through edge N+33, then result_o=0x00000002_0000000E after edge N+34. Drop start → ready_o=0 and result_o=0 on the next edge.
- DIV −7/2 (0xFFFFFFF9/0x00000002): result_o=0xFFFFFFFF_FFFFFFFD. DIV 7/−2: result_o=0x00000001_FFFFFFFD. DIVU 0xFFFFFFFF/1: result_o=0x00000000_FFFFFFFF.
- Overflow and zero cases:
  - DIV 0x80000000/0xFFFFFFFF: result_o=0x00000000_80000000.
  - DIVU 5/0: ready_o=1 after edge N+2, result_o=0.
- annul_i pulsed at edge N+10: FREE next edge, and ready_o never asserts. A fresh DIVU 9/3 then completes with 0x00000000_00000003 at 34-edge latency.
- Operand inputs changed every cycle after the latch edge: result still matches the latched operands.
- Mid-division disturbances:
  - rst asserted at edge N+20: all outputs 0 and state FREE the next edge; the next start behaves normally.
  - start_i dropped mid-ON: abort, same as annul.

Source files
------------

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for the EX stage (DIV/DIVU).
// One quotient bit per cycle on operand magnitudes, then a sign fix-up.
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start_i         request/hold a division until the result is consumed
//   annul_i         cancel an in-flight division
//   signed_div_i    1 = signed DIV, 0 = DIVU
//   opdata1_i/2_i   dividend / divisor (sampled only on the start edge)
//   result_o        {remainder, quotient}, registered
//   ready_o         result_o valid, registered
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        annul_i,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {ST_FREE, ST_BYZERO, ST_ON, ST_END} state_t;

    state_t      state, state_next;
    logic [5:0]  cnt;
    logic [32:0] rem;      // partial remainder
    logic [31:0] quo;      // dividend shifting out / quotient shifting in
    logic [31:0] dvsr;     // divisor magnitude
    logic        sgn, neg_a, neg_b;

    logic [31:0] mag_a, mag_b;
    logic [32:0] rem_sh;
    logic        take, abort, go;

    always_comb begin
        mag_a  = (signed_div_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
        mag_b  = (signed_div_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;
        rem_sh = {rem[31:0], quo[31]};
        // rem < dvsr always holds, so the shifted value minus dvsr fits in 32 bits
        take   = (rem_sh >= {1'b0, dvsr});
        abort  = annul_i || !start_i;
        go     = start_i && !annul_i;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_FREE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_FREE:   if (go) state_next = (opdata2_i == 32'd0) ? ST_BYZERO : ST_ON;
            ST_BYZERO: state_next = abort ? ST_FREE : ST_END;
            ST_ON: begin
                if (abort)             state_next = ST_FREE;
                else if (cnt == 6'd32) state_next = ST_END;
            end
            ST_END:    if (!start_i) state_next = ST_FREE;
            default:   state_next = ST_FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvsr     <= '0;
            sgn      <= 1'b0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                ST_FREE: begin
                    result_o <= '0;
                    ready_o  <= 1'b0;
                    if (go) begin
                        sgn   <= signed_div_i;
                        neg_a <= signed_div_i && opdata1_i[31];
                        neg_b <= signed_div_i && opdata2_i[31];
                        dvsr  <= mag_b;
                        cnt   <= '0;
                        rem   <= '0;
                        quo   <= mag_a;
                    end
                end
                ST_BYZERO: begin
                    if (!abort) begin
                        rem <= '0;
                        quo <= '0;
                    end
                end
                ST_ON: begin
                    if (!abort) begin
                        if (cnt != 6'd32) begin
                            rem <= take ? (rem_sh - {1'b0, dvsr}) : rem_sh;
                            quo <= {quo[30:0], take};
                            cnt <= cnt + 6'd1;
                        end else begin
                            // sign fix-up; negation wraps mod 2^32
                            quo <= (sgn && (neg_a ^ neg_b)) ? -quo : quo;
                            rem <= {1'b0, (sgn && neg_a) ? -rem[31:0] : rem[31:0]};
                        end
                    end
                end
                ST_END: begin
                    if (start_i) begin
                        result_o <= {rem[31:0], quo};
                        ready_o  <= 1'b1;
                    end else begin
                        result_o <= '0;
                        ready_o  <= 1'b0;
                    end
                end
                default: begin
                    result_o <= '0;
                    ready_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst, start, annul, sdiv;
    logic [31:0] op1, op2;
    logic [63:0] result;
    logic        ready;

    int checks = 0;
    int failures = 0;

    div_unit dut (
        .clk(clk), .rst(rst), .start_i(start), .annul_i(annul),
        .signed_div_i(sdiv), .opdata1_i(op1), .opdata2_i(op2),
        .result_o(result), .ready_o(ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sd;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a division, count edges until ready (bounded), check result,
    // hold one extra cycle, then release and check the clear.
    task automatic run_div(input string nm, input logic sd, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp,
                           input int lat, input bit scramble);
        int n;
        bit got;
        sdiv = sd; op1 = a; op2 = b; start = 1'b1; annul = 1'b0;
        tick();
        n = 0; got = 0;
        while (!got && n < 40) begin
            if (scramble) begin
                op1 = $urandom; op2 = $urandom; sdiv = 1'($urandom);
            end
            if (n == lat - 1) chk({nm, "_notready"}, 64'(ready), 64'd0);
            tick();
            n++;
            if (ready) got = 1;
        end
        chk({nm, "_lat"}, 64'(n), 64'(lat));
        chk({nm, "_res"}, result, exp);
        tick();
        chk({nm, "_hold"}, {63'd0, ready}, 64'd1);
        chk({nm, "_holdres"}, result, exp);
        start = 1'b0;
        tick();
        chk({nm, "_rdy_clr"}, 64'(ready), 64'd0);
        chk({nm, "_res_clr"}, result, 64'd0);
    endtask

    // Count edges until ready with start held (bounded).
    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 60) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        vecs[0]  = '{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 34};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'h00000002,   64'hFFFFFFFF_FFFFFFFD, 34};
        vecs[2]  = '{1'b1, 32'h00000007,   32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 34};
        vecs[3]  = '{1'b0, 32'hFFFFFFFF,   32'h00000001,   64'h00000000_FFFFFFFF, 34};
        vecs[4]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 34};
        vecs[5]  = '{1'b0, 32'd5,          32'd0,          64'h0,                 2};
        vecs[6]  = '{1'b1, 32'hFFFFFFFB,   32'd0,          64'h0,                 2};
        vecs[7]  = '{1'b0, 32'd9,          32'd3,          64'h00000000_00000003, 34};
        vecs[8]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   64'hFFFFFFFE_0000000E, 34};
        vecs[9]  = '{1'b0, 32'hFFFFFFF9,   32'd2,          64'h00000001_7FFFFFFC, 34};
        vecs[10] = '{1'b0, 32'd3,          32'd10,         64'h00000003_00000000, 34};
        vecs[11] = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   64'h80000000_00000000, 34};

        rst = 1'b1; start = 1'b0; annul = 1'b0; sdiv = 1'b0; op1 = '0; op2 = '0;
        tick(); tick();
        chk("reset_ready", 64'(ready), 64'd0);
        chk("reset_result", result, 64'd0);
        rst = 1'b0;
        tick();

        foreach (vecs[i])
            run_div($sformatf("vec%0d", i), vecs[i].sd, vecs[i].a, vecs[i].b,
                    vecs[i].exp, vecs[i].lat, 1'b0);

        // operands scrambled every cycle after the latch edge
        run_div("scramble", 1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 34, 1'b1);

        // annul in FREE blocks the start on that edge
        sdiv = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1; annul = 1'b1;
        tick();
        annul = 1'b0;
        run_div("annul_free", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34, 1'b0);

        // annul pulsed at N+10, start held: restart with 9/3 at N+11
        sdiv = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
        tick();                       // edge N
        repeat (9) tick();
        annul = 1'b1;
        tick();                       // edge N+10
        annul = 1'b0;
        chk("annul_ready", 64'(ready), 64'd0);
        op1 = 32'd9; op2 = 32'd3;
        wait_ready(n);
        chk("annul_restart_lat", 64'(n), 64'd35);
        chk("annul_restart_res", result, 64'h00000000_00000003);
        start = 1'b0;
        tick();
        chk("annul_release", 64'(ready), 64'd0);

        // reset at N+20, start held: restart with 3/10 at N+21
        sdiv = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
        tick();                       // edge N
        repeat (19) tick();
        rst = 1'b1;
        tick();                       // edge N+20
        rst = 1'b0;
        chk("rst_mid_ready", 64'(ready), 64'd0);
        chk("rst_mid_result", result, 64'd0);
        op1 = 32'd3; op2 = 32'd10;
        wait_ready(n);
        chk("rst_restart_lat", 64'(n), 64'd35);
        chk("rst_restart_res", result, 64'h00000003_00000000);
        start = 1'b0;
        tick();

        // start dropped mid-ON aborts; a new start then runs from scratch
        sdiv = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
        tick();
        repeat (5) tick();
        start = 1'b0;
        tick();
        chk("drop_ready", 64'(ready), 64'd0);
        run_div("drop_restart", 1'b1, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 34, 1'b0);

        // annul ignored in END
        sdiv = 1'b0; op1 = 32'd9; op2 = 32'd3; start = 1'b1;
        tick();
        wait_ready(n);
        chk("end_lat", 64'(n), 64'd34);
        annul = 1'b1;
        tick();
        chk("end_annul_ready", 64'(ready), 64'd1);
        chk("end_annul_res", result, 64'h00000000_00000003);
        annul = 1'b0; start = 1'b0;
        tick();
        chk("end_release", 64'(ready), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
